log_series_unit: RTL and testbench

Sequential fixed-point evaluator for ln(1+x), the inverse of the series-exponential datapath. It accepts a Q8.8 operand on a start pulse and accumulates N_TERMS terms of the alternating Taylor series using one shared 16x16 multiplier and a coefficient LUT. It then presents the result with a one-cycle done pulse and a threshold compare against inY. It sits beside the exponential unit, so the two can be chained for round-trip checks.

---
 rtl/log_series_pkg.sv | 19 +
 rtl/log_series_unit_coef.sv | 19 +
 rtl/log_series_unit.sv | 122 ++++++++++++
 tb/tb_log_series_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/log_series_pkg.sv
// Shared types and constants for the ln(1+x) series evaluator.
package log_series_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TERM = 2'd1,
    S_POW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int Q_FRAC = 8;

  // round(256/n) for n = 1..15; entry 0 holds c_1.
  localparam logic [15:0] COEF_TABLE [0:14] = '{
    16'd256, 16'd128, 16'd85, 16'd64, 16'd51, 16'd43, 16'd37, 16'd32,
    16'd28,  16'd26,  16'd23, 16'd21, 16'd20, 16'd18, 16'd17
  };

endpackage

// File: rtl/log_series_unit_coef.sv
// Combinational 4-bit term index to 8-bit series coefficient lookup.
module coef_lut_8_bit
  import log_series_pkg::*;
(
  input  logic [3:0] i_n,
  output logic [7:0] o_coef
);

  // c_1 = 256 wraps to 0 here; the caller substitutes 0x0100 for n == 1.
  always_comb begin
    o_coef = 8'd0;
    if (i_n != 4'd0) begin
      o_coef = COEF_TABLE[i_n - 4'd1][7:0];
    end else begin
      o_coef = 8'd0;
    end
  end

endmodule

// File: rtl/log_series_unit.sv
// Sequential Q8.8 ln(1+x) evaluator: alternating Taylor series over one shared
// 16x16 multiplier, with a done pulse, range error flag and threshold compare.
module log_series_unit
  import log_series_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] inX,
  input  logic [7:0]  inY,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        gt
);

  localparam logic [3:0] N_LAST = 4'(N_TERMS);

  state_t      r_state;
  logic [15:0] r_x;
  logic [15:0] r_p;
  logic [15:0] r_acc;
  logic [3:0]  r_n;
  logic [15:0] r_result;
  logic        r_err;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_lut;
  logic [15:0] w_coef;
  logic [15:0] w_mul_b;
  logic [31:0] w_prod;
  logic [15:0] w_prod_q;

  coef_lut_8_bit u_coef (
    .i_n    (r_n),
    .o_coef (w_lut)
  );

  // Single multiplier: p times c_n while in TERM, p times x while in POW.
  assign w_coef   = (r_n == 4'd1) ? 16'h0100 : {8'h00, w_lut};
  assign w_mul_b  = (r_state == S_POW) ? r_x : w_coef;
  assign w_prod   = r_p * w_mul_b;
  assign w_prod_q = 16'(w_prod >> Q_FRAC);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_x      <= 16'h0000;
      r_p      <= 16'h0000;
      r_acc    <= 16'h0000;
      r_n      <= 4'd0;
      r_result <= 16'h0000;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (inX[15:8] != 8'h00) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_x     <= inX;
              r_p     <= inX;
              r_acc   <= 16'h0000;
              r_n     <= 4'd1;
              r_err   <= 1'b0;
              r_state <= S_TERM;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_TERM: begin
          if (r_n[0]) begin
            r_acc <= r_acc + w_prod_q;
          end else begin
            r_acc <= r_acc - w_prod_q;
          end
          r_state <= S_POW;
        end
        S_POW: begin
          r_p <= w_prod_q;
          if (r_n == N_LAST) begin
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_n     <= r_n + 4'd1;
            r_state <= S_TERM;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out  = r_result;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign gt   = (inY > r_result[7:0]);

endmodule

// File: tb/tb_log_series_unit.sv
// Directed self-checking bench for log_series_unit (N_TERMS=8 and N_TERMS=1).
module tb_log_series_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start1;
  logic [15:0] inx8, inx1;
  logic [7:0]  iny8, iny1;
  logic [15:0] out8, out1;
  logic        busy8, busy1, done8, done1, err8, err1, gt8, gt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  log_series_unit #(.N_TERMS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .inX(inx8), .inY(iny8),
    .out(out8), .busy(busy8), .done(done8), .err(err8), .gt(gt8)
  );

  log_series_unit #(.N_TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .inX(inx1), .inY(iny1),
    .out(out1), .busy(busy1), .done(done1), .err(err1), .gt(gt1)
  );

  // Start cycle is cycle 0; returns at the falling edge inside cycle 1.
  task automatic start_op8(input logic [15:0] x);
    @(negedge clk);
    inx8 = x; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; inx8 = 16'hFFFF;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done8 === 1'b1) begin cyc = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    inx8 = 16'h0000; inx1 = 16'h0000; iny8 = 8'h05; iny1 = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (out8 !== 16'h0000) begin n_bad++; $display("FAIL reset_out got %h want 0000", out8); end
    n_cmp++; if ({busy8, done8, err8} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy8, done8, err8}); end
    n_cmp++; if (gt8 !== 1'b1) begin n_bad++; $display("FAIL reset_gt_nonzero got %b want 1", gt8); end
    iny8 = 8'h00; #1;
    n_cmp++; if (gt8 !== 1'b0) begin n_bad++; $display("FAIL reset_gt_zero got %b want 0", gt8); end
    rst = 1'b1;
  endtask

  task automatic test_zero;
    int cyc;
    start_op8(16'h0000);
    wait_done8(cyc);
    n_cmp++; if (cyc != 17) begin n_bad++; $display("FAIL zero_latency got %0d want 17", cyc); end
    n_cmp++; if (out8 !== 16'h0000) begin n_bad++; $display("FAIL zero_out got %h want 0000", out8); end
    n_cmp++; if ({err8, gt8, busy8} !== 3'b001) begin n_bad++; $display("FAIL zero_err_gt_busy got %b want 001", {err8, gt8, busy8}); end
    @(negedge clk);
    n_cmp++; if ({done8, busy8} !== 2'b00) begin n_bad++; $display("FAIL zero_after_done got %b want 00", {done8, busy8}); end
  endtask

  task automatic test_half;
    int cyc;
    start_op8(16'h0080);
    wait_done8(cyc);
    n_cmp++; if (cyc != 17) begin n_bad++; $display("FAIL half_latency got %0d want 17", cyc); end
    n_cmp++; if (out8 !== 16'h0067) begin n_bad++; $display("FAIL half_out got %h want 0067", out8); end
    iny8 = 8'h68; #1;
    n_cmp++; if (gt8 !== 1'b1) begin n_bad++; $display("FAIL half_gt_68 got %b want 1", gt8); end
    iny8 = 8'h67; #1;
    n_cmp++; if (gt8 !== 1'b0) begin n_bad++; $display("FAIL half_gt_67 got %b want 0", gt8); end
  endtask

  task automatic test_n1;
    int cyc;
    cyc = -1;
    @(negedge clk);
    inx1 = 16'h00FF; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; inx1 = 16'h0000;
    for (int c = 1; c <= 20; c++) begin
      if (done1 === 1'b1) begin cyc = c; break; end
      @(negedge clk);
    end
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL n1_latency got %0d want 3", cyc); end
    n_cmp++; if (out1 !== 16'h00FF) begin n_bad++; $display("FAIL n1_out got %h want 00ff", out1); end
  endtask

  task automatic test_illegal;
    int cyc;
    start_op8(16'h0100);
    n_cmp++; if ({done8, err8, busy8} !== 3'b111) begin n_bad++; $display("FAIL illegal_flags got %b want 111", {done8, err8, busy8}); end
    n_cmp++; if (out8 !== 16'h0067) begin n_bad++; $display("FAIL illegal_out_held got %h want 0067", out8); end
    @(negedge clk);
    n_cmp++; if ({done8, err8} !== 2'b01) begin n_bad++; $display("FAIL illegal_err_held got %b want 01", {done8, err8}); end
    start_op8(16'h0000);
    n_cmp++; if (err8 !== 1'b0) begin n_bad++; $display("FAIL illegal_err_clear got %b want 0", err8); end
    wait_done8(cyc);
    n_cmp++; if (cyc != 17) begin n_bad++; $display("FAIL illegal_recover_latency got %0d want 17", cyc); end
  endtask

  task automatic test_ignored_start;
    int done_cnt, done_at, busy_bad;
    done_cnt = 0; done_at = -1; busy_bad = 0;
    start_op8(16'h0080);
    for (int c = 1; c <= 20; c++) begin
      if (busy8 !== ((c <= 17) ? 1'b1 : 1'b0)) busy_bad++;
      if (done8 === 1'b1) begin done_cnt++; done_at = c; end
      start8 = (c == 4 || c == 10) ? 1'b1 : 1'b0;
      @(negedge clk);
      start8 = 1'b0;
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL ignored_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (done_at != 17) begin n_bad++; $display("FAIL ignored_done_cycle got %0d want 17", done_at); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL ignored_busy_profile got %0d bad cycles want 0", busy_bad); end
    n_cmp++; if (out8 !== 16'h0067) begin n_bad++; $display("FAIL ignored_out got %h want 0067", out8); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    start_op8(16'h0040);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy8, done8} !== 2'b00) begin n_bad++; $display("FAIL midreset_flags got %b want 00", {busy8, done8}); end
    n_cmp++; if (out8 !== 16'h0000) begin n_bad++; $display("FAIL midreset_out got %h want 0000", out8); end
    rst = 1'b1;
    start_op8(16'h0080);
    wait_done8(cyc);
    n_cmp++; if (cyc != 17) begin n_bad++; $display("FAIL midreset_rerun_latency got %0d want 17", cyc); end
    n_cmp++; if (out8 !== 16'h0067) begin n_bad++; $display("FAIL midreset_rerun_out got %h want 0067", out8); end
  endtask

  initial begin
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    inx8 = 16'h0000; inx1 = 16'h0000; iny8 = 8'h00; iny1 = 8'h00;
    test_reset;
    test_zero;
    test_half;
    test_n1;
    test_illegal;
    test_half;
    test_ignored_start;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
